time_counter: RTL and testbench
===============================

TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 SHALL have parameter HOUR_INIT, default 8'h00, BCD hour loaded on reset.
REQ-002 SHALL have parameter MIN_INIT, default 8'h00, BCD minute loaded on reset.
REQ-003 SHALL have port sec_clk  input  1  sole clock, 1 Hz, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_mode  input  1  debounced level, mode-advance request.
REQ-006 SHALL have port btn_inc  input  1  debounced level, increment-selected-field request.
REQ-007 SHALL have port hour_bcd  output  8  hours, two BCD digits.
REQ-008 SHALL have port min_bcd  output  8  minutes, two BCD digits.
REQ-009 SHALL have port sec_bcd  output  8  seconds, two BCD digits.
REQ-010 SHALL have port mode  output  2  2'b00 RUN, 2'b01 SET_HOUR, 2'b10 SET_MIN.
REQ-011 SHALL have port day_tick  output  1  one-cycle day-rollover pulse.
REQ-012 SHALL have port pm  output  1  afternoon flag (see Configuration).

Function
REQ-013 SHALL register btn_mode and btn_inc each edge; an event SHALL be a 0->1 change between consecutive samples, so one press yields exactly one action regardless of hold length.
REQ-014 SHALL implement FSM RUN -> SET_HOUR -> SET_MIN -> RUN, advancing one state per btn_mode event.
REQ-015 In RUN, seconds SHALL increment every edge: 59->00 carries to minutes, minutes 59->00 carry to hours, hours 23->00.
REQ-016 Each BCD digit SHALL stay in legal range at all times: sec/min tens 0-5, units 0-9; hours 00-23; no non-BCD code ever on outputs.
REQ-017 In SET_HOUR, a btn_inc event SHALL increment hours only, 23->00, no carry; minutes and seconds frozen.
REQ-018 In SET_MIN, a btn_inc event SHALL increment minutes only, 59->00, no carry to hours; seconds frozen.
REQ-019 btn_inc events in RUN SHALL be ignored.
REQ-020 On the edge leaving SET_MIN for RUN, seconds SHALL be cleared to 8'h00; counting resumes on the next edge.
REQ-021 Simultaneous btn_mode and btn_inc events SHALL apply the mode change only; the inc event is discarded.
REQ-022 day_tick SHALL be high for exactly the one cycle in which time reads 00:00:00 as a result of RUN rollover from 23:59:59; never on reset or set-mode wraps.
REQ-023 All outputs SHALL be registered; output update latency is zero cycles after the triggering edge.

Reset
REQ-024 Reset assertion SHALL immediately force mode=RUN, hour_bcd=HOUR_INIT, min_bcd=MIN_INIT, sec_bcd=8'h00, day_tick=0, pm per HOUR_INIT, button sample registers=0.
REQ-025 Reset asserted mid-set SHALL abandon the set operation; no partial edit survives.
REQ-026 A button held high through reset release SHALL NOT generate an event.

Configuration
REQ-027 Macro TIME_12H_EN SHALL select the display format; internal counting stays 00-23.
REQ-028 With TIME_12H_EN defined: hour_bcd SHALL show 12,01..11 (internal 00->12, 13..23->01..11), pm=1 for internal hours 12-23.
REQ-029 Without TIME_12H_EN: hour_bcd SHALL show internal 00-23 and pm SHALL be tied 0.

Verification
REQ-030 Reset, then 60 edges in RUN -> min_bcd=8'h01, sec_bcd=8'h00.
REQ-031 HOUR_INIT=8'h23, MIN_INIT=8'h59, reset, 59 edges -> 23:59:59; next edge -> 00:00:00 with day_tick=1 for that cycle only.
REQ-032 btn_mode event, then btn_inc held high 5 cycles from 23:xx -> exactly one increment, hour_bcd=8'h00, minutes unchanged.
REQ-033 In SET_MIN at 59, btn_inc event -> min_bcd=8'h00, hour_bcd unchanged; btn_mode event -> mode=RUN, sec_bcd=8'h00.
REQ-034 btn_mode and btn_inc rising on same edge in RUN -> mode=SET_HOUR, hour_bcd unchanged.
REQ-035 TIME_12H_EN defined, internal 13:00:00 -> hour_bcd=8'h01, pm=1; internal 00:00:00 -> hour_bcd=8'h12, pm=0.

Source files
------------

// File: rtl/time_counter.sv
// time_counter: BCD time-of-day clock on a 1 Hz clock with a RUN / SET_HOUR / SET_MIN editor.
// Define TIME_12H_EN to present hours in 12-hour form with a pm flag; counting is always 00-23.
module time_counter #(
  parameter logic [7:0] HOUR_INIT = 8'h00,
  parameter logic [7:0] MIN_INIT  = 8'h00
) (
  input  logic       sec_clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       day_tick,
  output logic       pm
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_t;

  mode_t      state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_d, sec_d;
  logic       tick_d;
  logic [7:0] disp_d;
  logic       pm_d;
  logic       mode_s, inc_s, armed;
  logic       mode_ev, inc_ev;

  // Two-digit BCD increment that wraps to 00 after the given top value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return '0;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

`ifdef TIME_12H_EN
  function automatic logic [7:0] to_disp(input logic [7:0] h);
    logic [4:0] b;
    b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (b == 5'd0)
      return 8'h12;
    if (b > 5'd12)
      b = b - 5'd12;
    if (b >= 5'd10)
      return {4'd1, 4'(b - 5'd10)};
    return {4'd0, b[3:0]};
  endfunction

  // BCD ordering matches numeric ordering, so a plain compare suffices.
  function automatic logic to_pm(input logic [7:0] h);
    return (h >= 8'h12);
  endfunction

  localparam logic [7:0] DISP_INIT = to_disp(HOUR_INIT);
  localparam logic       PM_INIT   = to_pm(HOUR_INIT);

  assign disp_d = to_disp(hour_d);
  assign pm_d   = to_pm(hour_d);
`else
  localparam logic [7:0] DISP_INIT = HOUR_INIT;
  localparam logic       PM_INIT   = 1'b0;

  assign disp_d = hour_d;
  assign pm_d   = 1'b0;
`endif

  // armed stays low for the first edge after reset so a button held through
  // reset release is absorbed into the sample registers without firing.
  assign mode_ev = armed & btn_mode & ~mode_s;
  assign inc_ev  = armed & btn_inc & ~inc_s & ~mode_ev;
  assign mode    = state_q;

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_bcd;
    sec_d   = sec_bcd;
    tick_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        sec_d = bcd_inc(sec_bcd, 8'h59);
        if (sec_bcd == 8'h59) begin
          min_d = bcd_inc(min_bcd, 8'h59);
          if (min_bcd == 8'h59) begin
            hour_d = bcd_inc(hour_q, 8'h23);
            tick_d = (hour_q == 8'h23);
          end
        end
        if (mode_ev)
          state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (mode_ev)
          state_d = SET_MIN;
        else if (inc_ev)
          hour_d = bcd_inc(hour_q, 8'h23);
      end
      SET_MIN: begin
        if (mode_ev) begin
          state_d = RUN;
          sec_d   = '0;
        end else if (inc_ev) begin
          min_d = bcd_inc(min_bcd, 8'h59);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge sec_clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      hour_q   <= HOUR_INIT;
      hour_bcd <= DISP_INIT;
      pm       <= PM_INIT;
      min_bcd  <= MIN_INIT;
      sec_bcd  <= '0;
      day_tick <= 1'b0;
      mode_s   <= 1'b0;
      inc_s    <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      hour_bcd <= disp_d;
      pm       <= pm_d;
      min_bcd  <= min_d;
      sec_bcd  <= sec_d;
      day_tick <= tick_d;
      mode_s   <= btn_mode;
      inc_s    <= btn_inc;
      armed    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: directed scenarios plus randomized buttons,
// checked against a seconds-of-day reference model.
module tb_time_counter;

  logic       sec_clk = 1'b0;
  logic       reset   = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] mode;
  logic       day_tick, pm;

  logic       w_mode = 1'b0, w_inc = 1'b0;
  logic [7:0] w_hour, w_min, w_sec;
  logic [1:0] w_md;
  logic       w_tk, w_pm;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time as seconds of day, mode as 0/1/2.
  int tsec, tsec_w, mmode;
  bit prev_m, prev_i, m_tick, w_tick;

  time_counter #(.HOUR_INIT(8'h00), .MIN_INIT(8'h00)) dut (
    .sec_clk(sec_clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .mode(mode), .day_tick(day_tick), .pm(pm)
  );

  time_counter #(.HOUR_INIT(8'h23), .MIN_INIT(8'h59)) dut_w (
    .sec_clk(sec_clk), .reset(reset), .btn_mode(w_mode), .btn_inc(w_inc),
    .hour_bcd(w_hour), .min_bcd(w_min), .sec_bcd(w_sec),
    .mode(w_md), .day_tick(w_tk), .pm(w_pm)
  );

  always #5 sec_clk = ~sec_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic logic [7:0] hr_disp(input int h);
`ifdef TIME_12H_EN
    if (h == 0) return 8'h12;
    if (h > 12) return bcd(h - 12);
    return bcd(h);
`else
    return bcd(h);
`endif
  endfunction

  function automatic logic hr_pm(input int h);
`ifdef TIME_12H_EN
    return (h >= 12);
`else
    return (h < 0);
`endif
  endfunction

  function automatic logic [27:0] expect_vec(input int t, input int md, input bit tk);
    return {hr_disp(t / 3600), bcd((t / 60) % 60), bcd(t % 60), 2'(md), tk, hr_pm(t / 3600)};
  endfunction

  function automatic logic [27:0] obs();
    return {hour_bcd, min_bcd, sec_bcd, mode, day_tick, pm};
  endfunction

  function automatic logic [27:0] obs_w();
    return {w_hour, w_min, w_sec, w_md, w_tk, w_pm};
  endfunction

  task automatic model_reset();
    tsec   = 0;
    tsec_w = 23 * 3600 + 59 * 60;
    mmode  = 0;
    prev_m = 1'b1;   // nothing sampled yet: a held button must first be seen low
    prev_i = 1'b1;
    m_tick = 1'b0;
    w_tick = 1'b0;
  endtask

  task automatic model_edge(input bit m, input bit i);
    bit mev, iev;
    int h, mi, s;
    mev = m && !prev_m;
    iev = i && !prev_i && !mev;
    h  = tsec / 3600;
    mi = (tsec / 60) % 60;
    s  = tsec % 60;
    m_tick = 1'b0;
    case (mmode)
      0: begin
        tsec   = (tsec + 1) % 86400;
        m_tick = (tsec == 0);
        if (mev) mmode = 1;
      end
      1: begin
        if (mev) mmode = 2;
        else if (iev) tsec = ((h + 1) % 24) * 3600 + mi * 60 + s;
      end
      default: begin
        if (mev) begin
          mmode = 0;
          tsec  = h * 3600 + mi * 60;
        end else if (iev) begin
          tsec = h * 3600 + ((mi + 1) % 60) * 60 + s;
        end
      end
    endcase
    prev_m = m;
    prev_i = i;
    tsec_w = (tsec_w + 1) % 86400;
    w_tick = (tsec_w == 0);
  endtask

  task automatic step(input bit m, input bit i);
    @(negedge sec_clk);
    btn_mode = m;
    btn_inc  = i;
    @(posedge sec_clk);
    model_edge(m, i);
    #1;
  endtask

  task automatic apply_reset(input bit m, input bit i);
    @(negedge sec_clk);
    btn_mode = m;
    btn_inc  = i;
    reset    = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge sec_clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b0, 1'b0);
    n_tests++;
    if (obs() !== expect_vec(tsec, mmode, m_tick)) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", obs(), expect_vec(tsec, mmode, m_tick));
    end
    n_tests++;
    if (obs_w() !== expect_vec(tsec_w, 0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_state_init: got %h required %h", obs_w(), expect_vec(tsec_w, 0, 1'b0));
    end
    release_reset();
  endtask

  task automatic test_rollover();
    apply_reset(1'b0, 1'b0);
    release_reset();
    repeat (59) step(1'b0, 1'b0);
    n_tests++;
    if (obs_w() !== expect_vec(23 * 3600 + 59 * 60 + 59, 0, 1'b0)) begin
      n_fail++;
      $display("FAIL pre_rollover: got %h required %h", obs_w(), expect_vec(23 * 3600 + 59 * 60 + 59, 0, 1'b0));
    end
    step(1'b0, 1'b0);
    n_tests++;
    if ({min_bcd, sec_bcd} !== 16'h0100) begin
      n_fail++;
      $display("FAIL minute_carry: got %h required %h", {min_bcd, sec_bcd}, 16'h0100);
    end
    n_tests++;
    if (obs_w() !== expect_vec(0, 0, 1'b1)) begin
      n_fail++;
      $display("FAIL day_rollover: got %h required %h", obs_w(), expect_vec(0, 0, 1'b1));
    end
    step(1'b0, 1'b0);
    n_tests++;
    if (w_tk !== 1'b0) begin
      n_fail++;
      $display("FAIL day_tick_width: got %b required 0", w_tk);
    end
  endtask

  task automatic test_set_hold();
    int guard;
    step(1'b1, 1'b0);
    n_tests++;
    if (mode !== 2'b01) begin
      n_fail++;
      $display("FAIL enter_set_hour: got %b required 01", mode);
    end
    step(1'b0, 1'b0);
    guard = 0;
    while (tsec / 3600 != 23 && guard < 30) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      guard++;
    end
    n_tests++;
    if (obs() !== expect_vec(tsec, mmode, m_tick)) begin
      n_fail++;
      $display("FAIL hour_23: got %h required %h", obs(), expect_vec(tsec, mmode, m_tick));
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1);
      n_tests++;
      if (obs() !== expect_vec(tsec, mmode, m_tick)) begin
        n_fail++;
        $display("FAIL inc_hold[%0d]: got %h required %h", k, obs(), expect_vec(tsec, mmode, m_tick));
      end
    end
    n_tests++;
    if ({hour_bcd, min_bcd} !== {hr_disp(0), bcd(1)}) begin
      n_fail++;
      $display("FAIL hour_wrap: got %h required %h", {hour_bcd, min_bcd}, {hr_disp(0), bcd(1)});
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_set_min();
    int guard;
    logic [7:0] hr_exp;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    guard = 0;
    while ((tsec / 60) % 60 != 59 && guard < 61) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      guard++;
    end
    n_tests++;
    if (obs() !== expect_vec(tsec, 2, 1'b0)) begin
      n_fail++;
      $display("FAIL min_59: got %h required %h", obs(), expect_vec(tsec, 2, 1'b0));
    end
    hr_exp = hr_disp(tsec / 3600);
    step(1'b0, 1'b1);
    n_tests++;
    if ({hour_bcd, min_bcd} !== {hr_exp, 8'h00}) begin
      n_fail++;
      $display("FAIL min_wrap: got %h required %h", {hour_bcd, min_bcd}, {hr_exp, 8'h00});
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_tests++;
    if ({mode, sec_bcd} !== {2'b00, 8'h00}) begin
      n_fail++;
      $display("FAIL exit_set_min: got %h required %h", {mode, sec_bcd}, {2'b00, 8'h00});
    end
    step(1'b0, 1'b0);
    n_tests++;
    if (sec_bcd !== 8'h01) begin
      n_fail++;
      $display("FAIL count_resume: got %h required 01", sec_bcd);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] hr_exp;
    hr_exp = hr_disp(tsec / 3600);
    step(1'b1, 1'b1);
    n_tests++;
    if ({mode, hour_bcd} !== {2'b01, hr_exp}) begin
      n_fail++;
      $display("FAIL simultaneous: got %h required %h", {mode, hour_bcd}, {2'b01, hr_exp});
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_tests++;
    if (obs() !== expect_vec(tsec, mmode, m_tick)) begin
      n_fail++;
      $display("FAIL back_to_run: got %h required %h", obs(), expect_vec(tsec, mmode, m_tick));
    end
  endtask

  task automatic test_reset_mid_set();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    apply_reset(1'b1, 1'b1);
    n_tests++;
    if (obs() !== expect_vec(tsec, mmode, m_tick)) begin
      n_fail++;
      $display("FAIL reset_mid_set: got %h required %h", obs(), expect_vec(tsec, mmode, m_tick));
    end
    release_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1);
      n_tests++;
      if (obs() !== expect_vec(tsec, mmode, m_tick)) begin
        n_fail++;
        $display("FAIL held_through_reset[%0d]: got %h required %h", k, obs(), expect_vec(tsec, mmode, m_tick));
      end
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_tests++;
    if (mode !== 2'b01) begin
      n_fail++;
      $display("FAIL press_after_reset: got %b required 01", mode);
    end
  endtask

  task automatic test_random();
    bit m, i;
    for (int k = 0; k < 800; k++) begin
      m = ($urandom_range(0, 9) == 0);
      i = ($urandom_range(0, 2) == 0);
      step(m, i);
      n_tests++;
      if (obs() !== expect_vec(tsec, mmode, m_tick)) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h required %h", k, obs(), expect_vec(tsec, mmode, m_tick));
      end
      n_tests++;
      if (obs_w() !== expect_vec(tsec_w, 0, w_tick)) begin
        n_fail++;
        $display("FAIL random_init[%0d]: got %h required %h", k, obs_w(), expect_vec(tsec_w, 0, w_tick));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rollover();
    test_set_hold();
    test_set_min();
    test_simultaneous();
    test_reset_mid_set();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
